// File: rtl/bbpll_dfe_pkg.sv
// ============================================================================
// Module      : bbpll_dfe_pkg
// Description : Shared widths, reset constants and LFSR helper for the
//               bang-bang PLL digital front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bbpll_dfe_pkg;

  localparam int CODE_W  = 8;
  localparam int FRAC_W  = 8;
  localparam int INTEG_W = CODE_W + FRAC_W;
  localparam int LFSR_W  = 16;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [INTEG_W-1:0] integ_t;
  typedef logic [LFSR_W-1:0]  lfsr_t;

  // 127.0 in 8.8 fixed point
  localparam integ_t INTEG_RESET = 16'h7F00;
  // 254 + 255/256, the largest value the integrator may hold
  localparam integ_t INTEG_MAX   = 16'hFEFF;
  localparam code_t  CODE_MAX    = 8'd254;

  localparam lfsr_t LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register map to bits 0,2,3,5
  localparam lfsr_t LFSR_TAPS = 16'h002D;

  // One shift of the Fibonacci LFSR: feedback enters at the MSB
  function automatic lfsr_t lfsr_next(input lfsr_t state);
    logic fb;
    fb = ^(state & LFSR_TAPS);
    return {fb, state[LFSR_W-1:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bbpll_dfe_lfsr.sv
// ============================================================================
// Module      : bbpll_dfe_lfsr
// Description : 16-bit Fibonacci pseudo-random generator used for DCO dither.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbpll_dfe_lfsr
  import bbpll_dfe_pkg::*;
#(
  parameter lfsr_t SEED = LFSR_SEED
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  output lfsr_t state
);

  // Advance one step per enabled cycle; reset reloads the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bbpll_dfe.sv
// ============================================================================
// Module      : bbpll_dfe
// Description : Bang-bang PLL digital front end. Samples the DCO clock on the
//               reference edge, runs a PI loop filter with frequency/phase
//               acquisition, thermometer-encodes the code into active-low
//               DCO row/column selects with a dither bit and flags lock.
//               Optional macro BBPLL_DFE_PRND_EN adds the LFSR dither source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bbpll_dfe
  import bbpll_dfe_pkg::*;
#(
  parameter int NUM_DCO_MATRIX_COLUMNS = 15,
  parameter int NUM_DCO_MATRIX_ROWS    = 17
) (
  input  logic                              referenceClock,
  input  logic                              reset,
  input  logic                              outputClock,
  input  logic                              freqAcqEnable,
  input  logic                              phaseAcqEnable,
  input  logic                              prndGeneratorEnable,
  input  logic                              prndDitheringEnable,
  input  logic                              dcoCtrlCodeOverride,
  input  logic [NUM_DCO_MATRIX_COLUMNS-2:0] dcoColSelectOverride,
  input  logic [NUM_DCO_MATRIX_ROWS-2:0]    dcoRowSelectOverride,
  input  logic [3:0]                        divisor,
  input  logic [6:0]                        integralConstant,
  input  logic [6:0]                        proportionalConstant,
  input  logic [8:0]                        lockThreshold,
  input  logic                              ldDivideEnable,
  output logic                              locked,
  output logic [NUM_DCO_MATRIX_ROWS-2:0]    dcoRowSelect,
  output logic [NUM_DCO_MATRIX_COLUMNS-2:0] dcoColumnSelect,
  output logic                              dcoDither
);

  localparam int COL_W = NUM_DCO_MATRIX_COLUMNS - 1;
  localparam int ROW_W = NUM_DCO_MATRIX_ROWS - 1;

  // ---------------------------------------------------------------- detector
  // pd_sample = 1 means the DCO edge came early (error -1), 0 means late (+1)
  logic pd_sample;

  // Bang-bang phase detector: DCO clock captured as data on every reference edge
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      pd_sample <= 1'b0;
    end else begin
      pd_sample <= outputClock;
    end
  end

  // -------------------------------------------------------------- decimation
  logic [3:0] dec_cnt;
  logic [3:0] div_last;
  logic [3:0] div_eff;
  logic       div_changed;
  logic       update;

  assign div_eff     = (divisor == 4'd0) ? 4'd1 : divisor;
  assign div_changed = (divisor != div_last);
  // A divisor change restarts the count and skips the strobe for that cycle
  assign update      = !div_changed && (dec_cnt >= (div_eff - 4'd1));

  // Loop update strobe generator, one strobe every div_eff reference cycles
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      dec_cnt  <= 4'd0;
      div_last <= 4'd1;
    end else begin
      div_last <= divisor;
      if (div_changed || update) begin
        dec_cnt <= 4'd0;
      end else begin
        dec_cnt <= dec_cnt + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------- integrator
  integ_t      integ;
  integ_t      integ_next;
  logic [10:0] integ_step;
  logic [16:0] integ_up;
  logic        integ_run;

  // Fast integral gain during frequency acquisition, until lock is declared
  assign integ_step = (freqAcqEnable && !locked) ? {integralConstant, 4'b0000}
                                                 : {4'b0000, integralConstant};
  assign integ_up   = {1'b0, integ} + {6'b0, integ_step};
  assign integ_run  = update && !dcoCtrlCodeOverride
                      && (freqAcqEnable || phaseAcqEnable);

  // Saturating add/subtract of one integral step in the direction of the error
  always_comb begin
    integ_next = integ;
    if (pd_sample) begin
      if (integ < {5'b0, integ_step}) begin
        integ_next = '0;
      end else begin
        integ_next = integ - {5'b0, integ_step};
      end
    end else begin
      if (integ_up > {1'b0, INTEG_MAX}) begin
        integ_next = INTEG_MAX;
      end else begin
        integ_next = integ_up[15:0];
      end
    end
  end

  // Integrator register, held while overridden or with both loops disabled
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      integ <= INTEG_RESET;
    end else if (integ_run) begin
      integ <= integ_next;
    end
  end

  // ------------------------------------------------------------ proportional
  // Proportional term in 8.8 units: constant has 1/16 LSB, so scale by 16
  logic [11:0] prop_term;
  logic [11:0] prop_mag;
  logic [17:0] prop_ext;

  assign prop_mag = {1'b0, proportionalConstant, 4'b0000};
  assign prop_ext = {{6{prop_term[11]}}, prop_term};

  // Proportional term captured alongside the integrator on each loop update
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      prop_term <= 12'd0;
    end else if (update && !dcoCtrlCodeOverride) begin
      if (!phaseAcqEnable) begin
        prop_term <= 12'd0;
      end else if (pd_sample) begin
        prop_term <= 12'd0 - prop_mag;
      end else begin
        prop_term <= prop_mag;
      end
    end
  end

  // ------------------------------------------------------------------ code
  logic [17:0] code_sum;
  code_t       code;

  assign code_sum = {2'b00, integ} + prop_ext;

  // Floor of integ + p, clamped to [0, CODE_MAX]; negative sums show bit 17
  always_comb begin
    code = code_sum[15:8];
    if (code_sum[17]) begin
      code = '0;
    end else if (code_sum[16:8] > {1'b0, CODE_MAX}) begin
      code = CODE_MAX;
    end
  end

  // --------------------------------------------------------------- encoder
  code_t            rows_q;
  code_t            rows_on;
  code_t            cols_raw;
  code_t            cols_on;
  logic [ROW_W-1:0] row_therm;
  logic [COL_W-1:0] col_therm;

  // Split the code into fully-on rows plus partial columns, then thermometer
  always_comb begin
    rows_q   = code / 8'(NUM_DCO_MATRIX_COLUMNS);
    rows_on  = (rows_q > 8'(ROW_W)) ? 8'(ROW_W) : rows_q;
    cols_raw = code - rows_on * 8'(NUM_DCO_MATRIX_COLUMNS);
    cols_on  = (cols_raw > 8'(COL_W)) ? 8'(COL_W) : cols_raw;
    row_therm = '1;
    col_therm = '1;
    for (int i = 0; i < ROW_W; i++) begin
      row_therm[i] = (8'(i) >= rows_on);
    end
    for (int j = 0; j < COL_W; j++) begin
      col_therm[j] = (8'(j) >= cols_on);
    end
  end

  // ---------------------------------------------------------------- dither
  logic dither_src;

`ifdef BBPLL_DFE_PRND_EN
  lfsr_t lfsr_state;
  logic  unused_lfsr;

  bbpll_dfe_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (referenceClock),
    .rst    (reset),
    .enable (prndGeneratorEnable),
    .state  (lfsr_state)
  );

  assign dither_src  = prndDitheringEnable ? lfsr_state[0] : integ[FRAC_W-1];
  assign unused_lfsr = ^lfsr_state[LFSR_W-1:1];
`else
  logic unused_prnd;

  // Without the generator the dither is the integrator's half-LSB bit
  assign dither_src  = integ[FRAC_W-1];
  assign unused_prnd = prndGeneratorEnable ^ prndDitheringEnable;
`endif

  // ---------------------------------------------------------- lock detector
  logic [9:0]  lock_cnt;
  logic        last_sample;
  logic [12:0] lock_thr;

  assign lock_thr = ldDivideEnable ? {lockThreshold, 4'b0000}
                                   : {4'b0000, lockThreshold};

  // Count consecutive updates whose error flips sign; a repeat clears it
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      lock_cnt    <= 10'd0;
      last_sample <= 1'b0;
    end else if (dcoCtrlCodeOverride) begin
      lock_cnt <= 10'd0;
    end else if (update) begin
      last_sample <= pd_sample;
      if (pd_sample != last_sample) begin
        if (lock_cnt != 10'h3FF) begin
          lock_cnt <= lock_cnt + 10'd1;
        end
      end else begin
        lock_cnt <= 10'd0;
      end
    end
  end

  // Registered lock flag, forced low while the loop is bypassed
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      locked <= 1'b0;
    end else begin
      locked <= !dcoCtrlCodeOverride && ({3'b000, lock_cnt} >= lock_thr);
    end
  end

  // --------------------------------------------------------------- outputs
  logic unused_bits;
  assign unused_bits = ^code_sum[7:0];

  // Registered DCO controls: override vectors or encoded code, plus dither
  always_ff @(posedge referenceClock or posedge reset) begin
    if (reset) begin
      dcoRowSelect    <= '1;
      dcoColumnSelect <= '1;
      dcoDither       <= 1'b0;
    end else begin
      if (dcoCtrlCodeOverride) begin
        dcoRowSelect    <= dcoRowSelectOverride;
        dcoColumnSelect <= dcoColSelectOverride;
      end else begin
        dcoRowSelect    <= row_therm;
        dcoColumnSelect <= col_therm;
      end
      dcoDither <= dither_src;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bbpll_dfe.sv
// ============================================================================
// Module      : tb_bbpll_dfe
// Description : Directed self-checking bench for bbpll_dfe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bbpll_dfe;

  logic        clk = 1'b0;
  logic        rst;
  logic        outputClock;
  logic        freqAcqEnable;
  logic        phaseAcqEnable;
  logic        prndGeneratorEnable;
  logic        prndDitheringEnable;
  logic        dcoCtrlCodeOverride;
  logic [13:0] dcoColSelectOverride;
  logic [15:0] dcoRowSelectOverride;
  logic [3:0]  divisor;
  logic [6:0]  integralConstant;
  logic [6:0]  proportionalConstant;
  logic [8:0]  lockThreshold;
  logic        ldDivideEnable;
  logic        locked;
  logic [15:0] dcoRowSelect;
  logic [13:0] dcoColumnSelect;
  logic        dcoDither;

  logic        toggle_en = 1'b0;
  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [15:0] model;
  logic        exp_dither;

  always #5 clk = ~clk;

  bbpll_dfe dut (
    .referenceClock       (clk),
    .reset                (rst),
    .outputClock          (outputClock),
    .freqAcqEnable        (freqAcqEnable),
    .phaseAcqEnable       (phaseAcqEnable),
    .prndGeneratorEnable  (prndGeneratorEnable),
    .prndDitheringEnable  (prndDitheringEnable),
    .dcoCtrlCodeOverride  (dcoCtrlCodeOverride),
    .dcoColSelectOverride (dcoColSelectOverride),
    .dcoRowSelectOverride (dcoRowSelectOverride),
    .divisor              (divisor),
    .integralConstant     (integralConstant),
    .proportionalConstant (proportionalConstant),
    .lockThreshold        (lockThreshold),
    .ldDivideEnable       (ldDivideEnable),
    .locked               (locked),
    .dcoRowSelect         (dcoRowSelect),
    .dcoColumnSelect      (dcoColumnSelect),
    .dcoDither            (dcoDither)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n reference cycles, ending on a falling edge; optionally toggle the DCO sample
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (toggle_en) outputClock = ~outputClock;
    end
  endtask

  task automatic do_reset();
    toggle_en = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_model_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  initial begin
    rst                  = 1'b1;
    outputClock          = 1'b0;
    freqAcqEnable        = 1'b0;
    phaseAcqEnable       = 1'b0;
    prndGeneratorEnable  = 1'b0;
    prndDitheringEnable  = 1'b0;
    dcoCtrlCodeOverride  = 1'b1;
    dcoColSelectOverride = 14'h3FFF;
    dcoRowSelectOverride = 16'hFFFF;
    divisor              = 4'd1;
    integralConstant     = 7'd0;
    proportionalConstant = 7'd0;
    lockThreshold        = 9'd100;
    ldDivideEnable       = 1'b0;

    // Reset state with override of all ones
    tick(2);
    check_eq("rst_rows", 32'(dcoRowSelect), 32'hFFFF);
    check_eq("rst_cols", 32'(dcoColumnSelect), 32'h3FFF);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_dither", 32'(dcoDither), 32'h0);
    rst = 1'b0;
    tick(3);
    check_eq("post_rst_rows", 32'(dcoRowSelect), 32'hFFFF);
    check_eq("post_rst_cols", 32'(dcoColumnSelect), 32'h3FFF);
    check_eq("post_rst_locked", 32'(locked), 32'h0);

    // Override pattern shows one cycle later
    dcoRowSelectOverride = 16'h1234;
    dcoColSelectOverride = 14'h0ABC;
    tick(1);
    check_eq("ovr_rows", 32'(dcoRowSelect), 32'h1234);
    check_eq("ovr_cols", 32'(dcoColumnSelect), 32'h0ABC);

    // Slow ramp: +1/256 per update, code 127 -> 128 after 256 updates
    dcoCtrlCodeOverride = 1'b0;
    outputClock         = 1'b0;
    integralConstant    = 7'd1;
    phaseAcqEnable      = 1'b1;
    do_reset();
    tick(256);
    check_eq("ramp127_rows", 32'(dcoRowSelect), 32'hFF00);
    check_eq("ramp127_cols", 32'(dcoColumnSelect), 32'h3F80);
    check_eq("ramp127_dither", 32'(dcoDither), 32'h1);
    tick(1);
    check_eq("ramp128_rows", 32'(dcoRowSelect), 32'hFF00);
    check_eq("ramp128_cols", 32'(dcoColumnSelect), 32'h3F00);
    check_eq("ramp128_dither", 32'(dcoDither), 32'h0);

    // Low saturation: code pinned at 0, no wrap
    outputClock      = 1'b1;
    freqAcqEnable    = 1'b1;
    phaseAcqEnable   = 1'b0;
    integralConstant = 7'd127;
    do_reset();
    tick(100);
    check_eq("satlo_rows", 32'(dcoRowSelect), 32'hFFFF);
    check_eq("satlo_cols", 32'(dcoColumnSelect), 32'h3FFF);
    check_eq("satlo_dither", 32'(dcoDither), 32'h0);
    check_eq("satlo_locked", 32'(locked), 32'h0);

    // High saturation with proportional boost: code clamps at 254
    outputClock          = 1'b0;
    phaseAcqEnable       = 1'b1;
    proportionalConstant = 7'd127;
    do_reset();
    tick(100);
    check_eq("sathi_rows", 32'(dcoRowSelect), 32'h0000);
    check_eq("sathi_cols", 32'(dcoColumnSelect), 32'h0000);
    check_eq("sathi_dither", 32'(dcoDither), 32'h1);

    // Asynchronous reset mid-cycle returns outputs at once
    #2 rst = 1'b1;
    #1;
    check_eq("async_rows", 32'(dcoRowSelect), 32'hFFFF);
    check_eq("async_cols", 32'(dcoColumnSelect), 32'h3FFF);
    check_eq("async_dither", 32'(dcoDither), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Proportional only: +2 codes when late, -2 codes when early
    freqAcqEnable        = 1'b0;
    integralConstant     = 7'd0;
    proportionalConstant = 7'd32;
    outputClock          = 1'b0;
    do_reset();
    tick(3);
    check_eq("prop_up_rows", 32'(dcoRowSelect), 32'hFF00);
    check_eq("prop_up_cols", 32'(dcoColumnSelect), 32'h3E00);
    outputClock = 1'b1;
    tick(3);
    check_eq("prop_dn_rows", 32'(dcoRowSelect), 32'hFF00);
    check_eq("prop_dn_cols", 32'(dcoColumnSelect), 32'h3FE0);

    // Divisor 4: one code step (fast gain, 16<<4 = 256) every 4th cycle
    outputClock          = 1'b0;
    freqAcqEnable        = 1'b1;
    integralConstant     = 7'd16;
    proportionalConstant = 7'd0;
    divisor              = 4'd4;
    do_reset();
    tick(5);
    check_eq("div_c5", 32'(dcoColumnSelect), 32'h3F80);
    tick(1);
    check_eq("div_c6", 32'(dcoColumnSelect), 32'h3F00);
    tick(3);
    check_eq("div_c9", 32'(dcoColumnSelect), 32'h3F00);
    tick(1);
    check_eq("div_c10", 32'(dcoColumnSelect), 32'h3E00);
    divisor = 4'd1;

    // Lock detector with alternating samples, threshold 8
    freqAcqEnable  = 1'b0;
    phaseAcqEnable = 1'b0;
    lockThreshold  = 9'd8;
    ldDivideEnable = 1'b0;
    outputClock    = 1'b1;
    do_reset();
    toggle_en = 1'b1;
    tick(9);
    check_eq("lock_e9", 32'(locked), 32'h0);
    tick(1);
    check_eq("lock_e10", 32'(locked), 32'h1);
    tick(2);
    toggle_en = 1'b0;
    tick(2);
    check_eq("lock_hold", 32'(locked), 32'h1);
    tick(2);
    check_eq("lock_drop", 32'(locked), 32'h0);
    ldDivideEnable = 1'b1;
    toggle_en = 1'b1;
    tick(60);
    check_eq("lock16_early", 32'(locked), 32'h0);
    tick(150);
    check_eq("lock16_late", 32'(locked), 32'h1);
    dcoCtrlCodeOverride = 1'b1;
    tick(2);
    check_eq("lock_ovr_clear", 32'(locked), 32'h0);
    dcoCtrlCodeOverride = 1'b0;
    toggle_en = 1'b0;
    ldDivideEnable = 1'b0;
    lockThreshold  = 9'd100;

    // Dither source: LFSR sequence from 0xACE1, then static when stopped
    outputClock         = 1'b0;
    prndGeneratorEnable = 1'b1;
    prndDitheringEnable = 1'b1;
    do_reset();
    model = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
`ifdef BBPLL_DFE_PRND_EN
      exp_dither = model[0];
`else
      exp_dither = 1'b0;
`endif
      check_eq($sformatf("dither_seq%0d", i), 32'(dcoDither), 32'(exp_dither));
      model = lfsr_model_next(model);
    end
    prndGeneratorEnable = 1'b0;
`ifdef BBPLL_DFE_PRND_EN
    exp_dither = model[0];
`else
    exp_dither = 1'b0;
`endif
    tick(1);
    check_eq("dither_stop0", 32'(dcoDither), 32'(exp_dither));
    tick(5);
    check_eq("dither_stop5", 32'(dcoDither), 32'(exp_dither));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
